// File: rtl/isq_enq_alloc_pkg.sv
// Shared backend ISU definitions for the issue-queue enqueue allocator:
// queue geometry, the RUN/RECOVER recovery state and small vector helpers.
package isq_enq_alloc_pkg;

  localparam int unsigned ISSUE_QUEUE_DEPTH = 8;
  localparam int unsigned ISSUE_QUEUE_LOG   = 3;

  typedef logic [ISSUE_QUEUE_DEPTH-1:0] iq_vec_t;
  typedef logic [ISSUE_QUEUE_LOG-1:0]   iq_idx_t;
  typedef logic [ISSUE_QUEUE_LOG:0]     iq_cnt_t;

  // Allocator recovery state: RUN accepts enqueues, RECOVER blocks them
  // while a redirect is being absorbed.
  typedef enum logic [0:0] {
    ISU_RUN     = 1'b0,
    ISU_RECOVER = 1'b1
  } isu_state_e;

  // Number of set bits in an entry vector.
  function automatic iq_cnt_t iq_popcount(input iq_vec_t vec);
    iq_cnt_t sum;
    sum = {(ISSUE_QUEUE_LOG+1){1'b0}};
    for (int i = 0; i < int'(ISSUE_QUEUE_DEPTH); i++) begin
      sum = sum + {{ISSUE_QUEUE_LOG{1'b0}}, vec[i]};
    end
    return sum;
  endfunction

  // One-hot entry vector selecting index idx.
  function automatic iq_vec_t iq_onehot(input iq_idx_t idx);
    iq_vec_t one;
    one = {{(ISSUE_QUEUE_DEPTH-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/isq_free_pick.sv
// Lowest-zero-bit priority encoder: returns the lowest index whose valid
// bit is clear, and whether any such entry exists.
module isq_free_pick
  import isq_enq_alloc_pkg::*;
(
  input  logic [ISSUE_QUEUE_DEPTH-1:0] valid_i,
  output logic [ISSUE_QUEUE_LOG-1:0]   idx_o,
  output logic                         found_o
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    idx_o   = {ISSUE_QUEUE_LOG{1'b0}};
    found_o = 1'b0;
    for (int i = int'(ISSUE_QUEUE_DEPTH) - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        idx_o   = iq_idx_t'(i);
        found_o = 1'b1;
      end else begin
        idx_o   = idx_o;
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/isq_enq_alloc.sv
// Issue-queue enqueue allocator: picks the lowest free entry, produces the
// zero-latency write enable, tracks per-entry valid bits and an incremental
// occupancy count, and blocks enqueue while a flush is being recovered.
module isq_enq_alloc
  import isq_enq_alloc_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enq_instr_valid,
  output logic                         enq_instr_ready,
  input  logic [ISSUE_QUEUE_DEPTH-1:0] iq_entries_clear_entry,
  input  logic                         flush_valid,
  input  logic [ISSUE_QUEUE_DEPTH-1:0] iq_entries_needflush,
  output logic [ISSUE_QUEUE_DEPTH-1:0] iq_entries_valid,
  output logic [ISSUE_QUEUE_DEPTH-1:0] iq_entries_wren_oh,
  output logic [ISSUE_QUEUE_LOG-1:0]   enq_ptr,
  output logic [ISSUE_QUEUE_LOG:0]     iq_count,
  output logic                         iq_full,
  output logic                         iq_empty
);

  isu_state_e state_q, state_d;
  iq_vec_t    valid_q, valid_d;
  iq_cnt_t    count_q, count_d;

  iq_idx_t    free_idx_s;
  logic       free_found_s;
  logic       fire_s;
  iq_vec_t    flush_mask_s;
  iq_vec_t    remove_s;

  // Free entry search works on the registered valid vector only, so a slot
  // cleared this cycle becomes allocatable from the next cycle on.
  isq_free_pick u_free_pick (
    .valid_i (valid_q),
    .idx_o   (free_idx_s),
    .found_o (free_found_s)
  );

  // Handshake, allocation pointer and one-hot write enable. Ready is gated
  // by reset_n so nothing appears to be written while reset is asserted.
  always_comb begin
    iq_full         = (count_q == iq_cnt_t'(ISSUE_QUEUE_DEPTH));
    iq_empty        = (count_q == {(ISSUE_QUEUE_LOG+1){1'b0}});
    enq_ptr         = free_found_s ? free_idx_s : {ISSUE_QUEUE_LOG{1'b0}};
    enq_instr_ready = reset_n && (state_q == ISU_RUN) && !iq_full && !flush_valid;
    fire_s          = enq_instr_valid && enq_instr_ready;
    if (fire_s) begin
      iq_entries_wren_oh = iq_onehot(enq_ptr);
    end else begin
      iq_entries_wren_oh = {ISSUE_QUEUE_DEPTH{1'b0}};
    end
  end

  // Next valid vector and count: removals only count on entries that are
  // actually valid, so stray clear/needflush bits are harmless.
  always_comb begin
    flush_mask_s = {ISSUE_QUEUE_DEPTH{1'b0}};
    if (flush_valid) begin
      flush_mask_s = iq_entries_needflush;
    end else begin
      flush_mask_s = {ISSUE_QUEUE_DEPTH{1'b0}};
    end
    remove_s = valid_q & (iq_entries_clear_entry | flush_mask_s);
    valid_d  = (valid_q & ~remove_s) | iq_entries_wren_oh;
    count_d  = count_q + {{ISSUE_QUEUE_LOG{1'b0}}, fire_s} - iq_popcount(remove_s);
  end

  // Recovery FSM: stay in RECOVER for as long as flushes keep arriving.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ISU_RUN: begin
        if (flush_valid) begin
          state_d = ISU_RECOVER;
        end else begin
          state_d = ISU_RUN;
        end
      end
      ISU_RECOVER: begin
        if (flush_valid) begin
          state_d = ISU_RECOVER;
        end else begin
          state_d = ISU_RUN;
        end
      end
      default: begin
        state_d = ISU_RUN;
      end
    endcase
  end

  // State, valid and count registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ISU_RUN;
      valid_q <= {ISSUE_QUEUE_DEPTH{1'b0}};
      count_q <= {(ISSUE_QUEUE_LOG+1){1'b0}};
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign iq_entries_valid = valid_q;
  assign iq_count         = count_q;

endmodule

// File: tb/tb_isq_enq_alloc.sv
// Self-checking bench for isq_enq_alloc: directed scenarios plus random
// traffic compared against an entry-array reference model.
module tb_isq_enq_alloc;

  localparam int D = 8;

  logic       clock;
  logic       reset_n;
  logic       enq_instr_valid;
  logic       enq_instr_ready;
  logic [7:0] iq_entries_clear_entry;
  logic       flush_valid;
  logic [7:0] iq_entries_needflush;
  logic [7:0] iq_entries_valid;
  logic [7:0] iq_entries_wren_oh;
  logic [2:0] enq_ptr;
  logic [3:0] iq_count;
  logic       iq_full;
  logic       iq_empty;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model: one bit per entry and a recovering flag
  bit mv [D];
  bit mrec;

  isq_enq_alloc dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .enq_instr_valid        (enq_instr_valid),
    .enq_instr_ready        (enq_instr_ready),
    .iq_entries_clear_entry (iq_entries_clear_entry),
    .flush_valid            (flush_valid),
    .iq_entries_needflush   (iq_entries_needflush),
    .iq_entries_valid       (iq_entries_valid),
    .iq_entries_wren_oh     (iq_entries_wren_oh),
    .enq_ptr                (enq_ptr),
    .iq_count               (iq_count),
    .iq_full                (iq_full),
    .iq_empty               (iq_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(mv[i]);
    return n;
  endfunction

  function automatic logic [7:0] model_vec();
    logic [7:0] v = 8'h00;
    for (int i = 0; i < D; i++) v[i] = mv[i];
    return v;
  endfunction

  // Drive one cycle of inputs at negedge, compare every output against the
  // model, then advance the model to what the next posedge should produce.
  task automatic step(input bit v, input logic [7:0] clr, input bit fl, input logic [7:0] nf);
    int   ptr;
    bit   found;
    bit   rdy;
    int   cnt;
    logic [7:0] wexp;
    @(negedge clock);
    enq_instr_valid        = v;
    iq_entries_clear_entry = clr;
    flush_valid            = fl;
    iq_entries_needflush   = nf;
    #1;
    cnt   = model_count();
    ptr   = 0;
    found = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (!found && !mv[i]) begin
        ptr   = i;
        found = 1'b1;
      end
    end
    rdy  = !mrec && (cnt < D) && !fl;
    wexp = (v && rdy) ? (8'h01 << ptr) : 8'h00;
    chk("ready",   {31'd0, enq_instr_ready}, {31'd0, rdy});
    chk("enq_ptr", {29'd0, enq_ptr}, ptr);
    chk("wren_oh", {24'd0, iq_entries_wren_oh}, {24'd0, wexp});
    chk("valid",   {24'd0, iq_entries_valid}, {24'd0, model_vec()});
    chk("count",   {28'd0, iq_count}, cnt);
    chk("full",    {31'd0, iq_full}, {31'd0, (cnt == D)});
    chk("empty",   {31'd0, iq_empty}, {31'd0, (cnt == 0)});
    for (int i = 0; i < D; i++) begin
      if (mv[i] && (clr[i] || (fl && nf[i]))) mv[i] = 1'b0;
    end
    if (v && rdy) mv[ptr] = 1'b1;
    mrec = fl;
  endtask

  // Assert reset between edges with an enqueue pending, check the reset
  // view, hold over a posedge and release with quiet inputs.
  task automatic pulse_reset();
    @(negedge clock);
    enq_instr_valid        = 1'b1;
    iq_entries_clear_entry = 8'h00;
    flush_valid            = 1'b0;
    iq_entries_needflush   = 8'h00;
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < D; i++) mv[i] = 1'b0;
    mrec = 1'b0;
    chk("rst_valid",   {24'd0, iq_entries_valid}, 32'h0);
    chk("rst_count",   {28'd0, iq_count}, 32'h0);
    chk("rst_empty",   {31'd0, iq_empty}, 32'h1);
    chk("rst_full",    {31'd0, iq_full}, 32'h0);
    chk("rst_wren",    {24'd0, iq_entries_wren_oh}, 32'h0);
    chk("rst_enq_ptr", {29'd0, enq_ptr}, 32'h0);
    @(negedge clock);
    enq_instr_valid = 1'b0;
    reset_n         = 1'b1;
  endtask

  initial begin
    logic [7:0] clr;
    int r;
    reset_n                = 1'b0;
    enq_instr_valid        = 1'b0;
    iq_entries_clear_entry = 8'h00;
    flush_valid            = 1'b0;
    iq_entries_needflush   = 8'h00;
    for (int i = 0; i < D; i++) mv[i] = 1'b0;
    mrec = 1'b0;
    repeat (2) @(posedge clock);
    pulse_reset();

    // eight back-to-back enqueues fill entries 0..7 in order
    for (int i = 0; i < D; i++) begin
      step(1'b1, 8'h00, 1'b0, 8'h00);
      chk("fill_wren", {24'd0, iq_entries_wren_oh}, 32'h1 << i);
    end
    step(1'b1, 8'h00, 1'b0, 8'h00);
    chk("full_ready", {31'd0, enq_instr_ready}, 32'h0);
    chk("full_flag",  {31'd0, iq_full}, 32'h1);

    // clear entry 3 while full; upstream held valid refills it next cycle
    step(1'b1, 8'h08, 1'b0, 8'h00);
    chk("clr_ready_same", {31'd0, enq_instr_ready}, 32'h0);
    step(1'b1, 8'h00, 1'b0, 8'h00);
    chk("refill_ready", {31'd0, enq_instr_ready}, 32'h1);
    chk("refill_ptr",   {29'd0, enq_ptr}, 32'd3);
    chk("refill_wren",  {24'd0, iq_entries_wren_oh}, 32'h08);
    step(1'b0, 8'h00, 1'b0, 8'h00);
    chk("refill_count", {28'd0, iq_count}, 32'd8);

    // partial flush of the upper half
    step(1'b1, 8'h00, 1'b1, 8'hF0);
    chk("flush_ready0", {31'd0, enq_instr_ready}, 32'h0);
    step(1'b0, 8'h00, 1'b0, 8'h00);
    chk("recover_ready", {31'd0, enq_instr_ready}, 32'h0);
    chk("flush_valid",   {24'd0, iq_entries_valid}, 32'h0F);
    chk("flush_count",   {28'd0, iq_count}, 32'd4);
    chk("flush_ptr",     {29'd0, enq_ptr}, 32'd4);

    // enqueue and clear in the same cycle
    step(1'b1, 8'h02, 1'b0, 8'h00);
    chk("encl_wren", {24'd0, iq_entries_wren_oh}, 32'h10);
    step(1'b0, 8'h00, 1'b0, 8'h00);
    chk("encl_valid", {24'd0, iq_entries_valid}, 32'h1D);
    chk("encl_count", {28'd0, iq_count}, 32'd4);

    // two consecutive flushes keep the allocator in RECOVER
    step(1'b1, 8'h00, 1'b1, 8'h00);
    step(1'b1, 8'h00, 1'b1, 8'h00);
    step(1'b1, 8'h00, 1'b0, 8'h00);
    chk("dflush_ready_hold", {31'd0, enq_instr_ready}, 32'h0);
    step(1'b1, 8'h00, 1'b0, 8'h00);
    chk("dflush_ready_back", {31'd0, enq_instr_ready}, 32'h1);

    // flush everything, including stray needflush bits on invalid entries
    step(1'b0, 8'h00, 1'b1, 8'hFF);
    step(1'b0, 8'h00, 1'b0, 8'h00);
    chk("killall_valid", {24'd0, iq_entries_valid}, 32'h0);
    chk("killall_empty", {31'd0, iq_empty}, 32'h1);
    step(1'b0, 8'h00, 1'b0, 8'h00);

    // build 0x3C then reset mid-stream
    for (int i = 0; i < 6; i++) step(1'b1, 8'h00, 1'b0, 8'h00);
    step(1'b0, 8'h01, 1'b0, 8'h00);
    step(1'b0, 8'h02, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 8'h00);
    chk("pre_rst_valid", {24'd0, iq_entries_valid}, 32'h3C);
    pulse_reset();
    step(1'b1, 8'h00, 1'b0, 8'h00);
    chk("post_rst_ready", {31'd0, enq_instr_ready}, 32'h1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      r   = $urandom_range(0, 11);
      clr = (r < D) ? (8'h01 << r) : 8'h00;
      if (($urandom % 8) == 0) begin
        step(($urandom % 4) != 0, clr, 1'b1,
             (($urandom % 4) == 0) ? 8'hFF : 8'($urandom));
      end else begin
        step(($urandom % 4) != 0, clr, 1'b0, 8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/isq_enq_alloc.md
ISQ_ENQ_ALLOC -- requirements
Module: isq_enq_alloc

Interface
REQ-001 Constant: ISSUE_QUEUE_DEPTH, default 8, number of issue-queue entries (from defines.sv).
REQ-002 Constant: ISSUE_QUEUE_LOG, default 3, equal to log2(ISSUE_QUEUE_DEPTH) (from defines.sv).
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enq_instr_valid  input  1  upstream has an instruction to enqueue.
REQ-006 enq_instr_ready  output  1  allocator accepts an instruction this cycle.
REQ-007 iq_entries_clear_entry  input  DEPTH  one-hot (or zero) dequeue clear from the age-based dequeue policy.
REQ-008 flush_valid  input  1  redirect/flush event this cycle.
REQ-009 iq_entries_needflush  input  DEPTH  entries to kill when flush_valid=1.
REQ-010 iq_entries_valid  output  DEPTH  registered per-entry valid vector.
REQ-011 iq_entries_wren_oh  output  DEPTH  one-hot write enable of the allocated entry; zero when no enqueue fires.
REQ-012 enq_ptr  output  LOG  index of the entry that receives the next enqueue.
REQ-013 iq_count  output  LOG+1  registered number of valid entries.
REQ-014 iq_full / iq_empty  output  1 each  iq_count==DEPTH / iq_count==0.

Function
REQ-015 Enqueue fire SHALL be enq_instr_valid && enq_instr_ready in the same cycle.
REQ-016 enq_instr_ready SHALL be combinational: state==RUN && !iq_full && !flush_valid.
REQ-017 enq_ptr SHALL be the lowest index i with iq_entries_valid[i]==0, computed from registered valid; 0 when full.
REQ-018 iq_entries_wren_oh SHALL equal onehot(enq_ptr) on fire, else 0; zero-latency (same cycle).
REQ-019 Next valid SHALL be (valid & ~clear & ~(flush_valid ? needflush : 0)) | wren_oh, registered at posedge.
REQ-020 A slot freed by clear in cycle N SHALL NOT be allocatable before cycle N+1.
REQ-021 Simultaneous enqueue and clear (different entries) SHALL both take effect; iq_count net change = +1-1 = 0.
REQ-022 Clear or needflush bits on invalid entries SHALL be ignored without error.
REQ-023 iq_count SHALL equal popcount(iq_entries_valid) at every cycle, updated incrementally (+fire, -popcount of effective removals).
REQ-024 State machine: RUN, RECOVER; RUN --flush_valid--> RECOVER; RECOVER --!flush_valid--> RUN; RECOVER --flush_valid--> RECOVER.
REQ-025 In RECOVER no enqueue SHALL fire; dequeue clears SHALL still be applied.
REQ-026 Flush with needflush all-ones SHALL yield valid=0, iq_count=0, iq_empty=1 next cycle.
REQ-027 A full queue SHALL hold enq_instr_ready low; upstream valid held high SHALL be accepted the cycle after any clear.

Reset
REQ-028 On reset_n low (asynchronous): iq_entries_valid=0, iq_count=0, state=RUN.
REQ-029 Derived outputs during reset: iq_empty=1, iq_full=0, wren_oh=0, enq_ptr=0.
REQ-030 Reset asserted mid-enqueue SHALL discard the enqueue; first cycle after release enq_instr_ready=1 (flush_valid low).

Structure
REQ-031 DEPTH/LOG constants SHALL come from defines.sv; the RUN/RECOVER state typedef SHALL live in the shared backend ISU package.
REQ-032 One sub-module isq_free_pick (lowest-zero-bit priority encoder: valid vector -> index, found) SHALL be instantiated.
REQ-033 iq_entries_valid and iq_entries_wren_oh SHALL connect directly to the dequeue policy's matching inputs.

Verification
REQ-034 Reset, then 8 back-to-back enqueues -> wren_oh 0x01,0x02,...,0x80; iq_full=1, ready=0 on 9th cycle.
REQ-035 Full queue, clear 0x08 with valid held -> next cycle ready=1, enq_ptr=3, wren_oh=0x08, count returns to 8.
REQ-036 valid=0x0F, enqueue + clear 0x02 same cycle -> valid=0x1D, count=4.
REQ-037 valid=0xFF, flush_valid with needflush 0xF0 -> ready=0 that cycle and next (RECOVER), valid=0x0F, count=4, enq_ptr=4.
REQ-038 Flush on two consecutive cycles -> stays RECOVER, ready=0 until one cycle after last flush.
REQ-039 reset_n pulsed low mid-stream with valid=0x3C -> valid=0 immediately, count=0, empty=1.
